// File: rtl/pg_controller.sv
// Per-port power-gating controller: epoch-driven drain/gate decisions under an off-port budget,
// with wake by demand, router congestion or forced request, and a fixed wake latency.
module pg_port #(
   parameter int PORT_LOAD_W = 6,
   parameter int LOW_TH      = 2,
   parameter int HIGH_TH     = 8,
   parameter int WAKE_LAT    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   evalStb_i,
   input  logic [PORT_LOAD_W-1:0] load_i,
   input  logic                   routerHigh_i,
   input  logic                   grant_i,
   input  logic                   busy_i,
   input  logic                   forceWake_i,
   output logic [1:0]             status_o,
   output logic                   offNext_o,
   output logic                   cand_o
);
   typedef enum logic [1:0] {
      ACTIVE   = 2'd0,
      INACTIVE = 2'd1,
      DRAIN    = 2'd2,
      WAKE     = 2'd3
   } state_e;

   localparam logic [PORT_LOAD_W-1:0] LOW_L  = PORT_LOAD_W'(LOW_TH);
   localparam logic [PORT_LOAD_W-1:0] HIGH_L = PORT_LOAD_W'(HIGH_TH);
   localparam logic [3:0]             CNT_INIT = 4'(WAKE_LAT - 1);

   state_e     st_q, st_d;
   logic [3:0] cnt_q, cnt_d;

   // A forced wake on an ACTIVE port keeps it out of the candidate set entirely.
   assign cand_o = (st_q == ACTIVE) && evalStb_i && (load_i < LOW_L) &&
                   !routerHigh_i && !forceWake_i;

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
         ACTIVE: begin
            if (grant_i) st_d = DRAIN;
         end
         DRAIN: begin
            if (forceWake_i) begin
               st_d  = WAKE;
               cnt_d = CNT_INIT;
            end else if (!busy_i) begin
               st_d = INACTIVE;
            end
         end
         INACTIVE: begin
            if (forceWake_i || (evalStb_i && ((load_i >= HIGH_L) || routerHigh_i))) begin
               st_d  = WAKE;
               cnt_d = CNT_INIT;
            end
         end
         WAKE: begin
            if (cnt_q == 4'd0) st_d = ACTIVE;
            else               cnt_d = cnt_q - 4'd1;
         end
         default: st_d = ACTIVE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q  <= ACTIVE;
         cnt_q <= 4'd0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   assign status_o  = st_q;
   assign offNext_o = (st_d == DRAIN) || (st_d == INACTIVE);
endmodule

module pg_controller #(
   parameter int PORT_LOAD_W   = 6,
   parameter int ROUTER_LOAD_W = 8,
   parameter int LOW_TH        = 2,
   parameter int HIGH_TH       = 8,
   parameter int ROUTER_TH     = 24,
   parameter int MAX_OFF       = 2,
   parameter int WAKE_LAT      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pgEnable,
   input  logic [ROUTER_LOAD_W-1:0] routerLoad,
   input  logic [4*PORT_LOAD_W-1:0] portLoad,
   input  logic [3:0]               portBusy,
   input  logic [3:0]               forceWake,
   output logic [7:0]               portStatus,
   output logic [2:0]               offCount
);
   localparam logic [ROUTER_LOAD_W-1:0] RTH_L = ROUTER_LOAD_W'(ROUTER_TH);

   logic                  evalStb_q;
   logic [2:0]            offCount_q, offCount_d;
   logic                  routerHigh;
   logic [3:0]            cand, grant, offNext;
   logic [3:0][1:0]       status;
   logic [3:0]            budget;

   assign routerHigh = routerLoad >= RTH_L;

   // Budget is fixed at the start of the evaluation; wakes in the same cycle
   // do not return slots, and index order gives E, W, N, S priority.
   always_comb begin
      grant  = 4'b0;
      budget = 4'(MAX_OFF) - {1'b0, offCount_q};
      for (int i = 0; i < 4; i++) begin
         if (cand[i] && (budget != 4'd0)) begin
            grant[i] = 1'b1;
            budget   = budget - 4'd1;
         end
      end
   end

   always_comb begin
      offCount_d = 3'd0;
      for (int i = 0; i < 4; i++) offCount_d = offCount_d + {2'b0, offNext[i]};
   end

   for (genvar p = 0; p < 4; p++) begin : g_port
      pg_port #(
         .PORT_LOAD_W (PORT_LOAD_W),
         .LOW_TH      (LOW_TH),
         .HIGH_TH     (HIGH_TH),
         .WAKE_LAT    (WAKE_LAT)
      ) u_port (
         .clk          (clk),
         .reset        (reset),
         .evalStb_i    (evalStb_q),
         .load_i       (portLoad[p*PORT_LOAD_W +: PORT_LOAD_W]),
         .routerHigh_i (routerHigh),
         .grant_i      (grant[p]),
         .busy_i       (portBusy[p]),
         .forceWake_i  (forceWake[p]),
         .status_o     (status[p]),
         .offNext_o    (offNext[p]),
         .cand_o       (cand[p])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         evalStb_q  <= 1'b0;
         offCount_q <= 3'd0;
      end else begin
         evalStb_q  <= pgEnable;
         offCount_q <= offCount_d;
      end
   end

   assign portStatus = status;
   assign offCount   = offCount_q;
endmodule
